// File: rtl/gf_frob_pkg.sv
// rtl/gf_frob_pkg.sv - shared types and constants for the Frobenius power sequencer
//
// Contents:
//   state_e  : sequencer states IDLE / RUN / DONE
//   AES_POLY : default reduction polynomial x^8 + x^4 + x^3 + x + 1
//   kw_of()  : width of the squaring count for a field of degree w
package gf_frob_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [8:0] AES_POLY = 9'h11B;

    // Count width is clog2(w), but never narrower than one bit.
    function automatic int kw_of(input int w);
        int c;
        c = $clog2(w);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/gf_sq_step.sv
// rtl/gf_sq_step.sv - single combinational GF(2^W) squaring step
//
// Ports:
//   a    in  W : operand
//   mode in  1 : 0 = normal basis (left rotate), 1 = polynomial basis mod POLY
//   q    out W : a squared in the selected basis
module gf_sq_step #(
    parameter int         W    = 8,
    parameter logic [W:0] POLY = 9'h11B
) (
    input  logic [W-1:0] a,
    input  logic         mode,
    output logic [W-1:0] q
);

    localparam logic [2*W-2:0] POLY_EXT = (2*W-1)'(POLY);

    logic [2*W-2:0] p;

    always_comb begin
        // Squaring in GF(2)[x] has no cross terms: bit i lands on bit 2i.
        p = '0;
        for (int i = 0; i < W; i++) begin
            p[2*i] = a[i];
        end
        // Long division by POLY from the top degree down to degree W.
        for (int i = 2*W-2; i >= W; i--) begin
            if (p[i]) begin
                p = p ^ (POLY_EXT << (i - W));
            end
        end
        q = mode ? p[W-1:0] : {a[W-2:0], a[W-1]};
    end

endmodule

// File: rtl/gf_frob_seq.sv
// rtl/gf_frob_seq.sv - iterative Frobenius power A^(2^k) over GF(2^W)
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake
//   in_a, in_k, in_mode   : operand, squaring count, basis select
//   in_tag                : channel tag, returned with the result
//   out_valid / out_ready : result handshake
//   out_q, out_tag        : result A^(2^k) and its tag
//   busy                  : sequencer not idle
module gf_frob_seq
    import gf_frob_pkg::*;
#(
    parameter int         W    = 8,
    parameter logic [W:0] POLY = (W+1)'(AES_POLY),
    parameter int         TAGW = 2,
    localparam int        KW   = kw_of(W)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_a,
    input  logic [KW-1:0]   in_k,
    input  logic            in_mode,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_q,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [KW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [W-1:0]    sq_q;

    gf_sq_step #(
        .W    (W),
        .POLY (POLY)
    ) u_sq (
        .a    (a_q),
        .mode (mode_q),
        .q    (sq_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        tag_d     = tag_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            RUN: begin
                a_d   = sq_q;
                cnt_d = cnt_q - KW'(1);
                if (cnt_q == KW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Completing the result frees the operand register this edge,
                // so a new request may load in the same handoff.
                in_ready  = out_ready;
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (in_valid && in_ready) begin
            a_d     = in_a;
            cnt_d   = in_k;
            mode_d  = in_mode;
            tag_d   = in_tag;
            state_d = (in_k != '0) ? RUN : DONE;
        end
    end

    // Outputs come straight from registers; nothing from in_* reaches out_*.
    assign out_q   = a_q;
    assign out_tag = tag_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_gf_frob_seq.sv
// tb/tb_gf_frob_seq.sv - self-checking bench for gf_frob_seq
module tb_gf_frob_seq;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, in_mode, out_valid, out_ready, busy;
    logic [7:0] in_a, out_q;
    logic [2:0] in_k;
    logic [1:0] in_tag, out_tag;

    logic       d2_in_valid, d2_in_ready, d2_in_mode, d2_out_valid, d2_out_ready, d2_busy;
    logic [1:0] d2_in_a, d2_out_q;
    logic [0:0] d2_in_k;
    logic [1:0] d2_in_tag, d2_out_tag;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    gf_frob_seq #(.W(8), .POLY(9'h11B), .TAGW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_k(in_k),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_tag(out_tag),
        .busy(busy)
    );

    gf_frob_seq #(.W(2), .POLY(3'b111), .TAGW(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_a(d2_in_a), .in_k(d2_in_k),
        .in_mode(d2_in_mode), .in_tag(d2_in_tag),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_q(d2_out_q), .out_tag(d2_out_tag),
        .busy(d2_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: field multiply by shift-and-add with xtime reduction.
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r = 8'h00;
        logic [7:0] t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) r = r ^ t;
            t = t[7] ? ((t << 1) ^ 8'h1B) : (t << 1);
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_frob(input logic [7:0] x, input int k, input logic m);
        logic [7:0] r;
        int kk = k % 8;
        if (!m) begin
            r = (kk == 0) ? x : ((x << kk) | (x >> (8 - kk)));
        end else begin
            r = x;
            for (int i = 0; i < kk; i++) r = ref_mul(r, r);
        end
        return r;
    endfunction

    typedef struct {
        logic [7:0] a;
        logic [2:0] k;
        logic       mode;
        logic [1:0] tag;
        logic [7:0] q;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    task automatic run8(input logic [7:0] a, input logic [2:0] k, input logic m,
                        input logic [1:0] t, output logic [7:0] q, output logic [1:0] tg,
                        output int lat);
        @(negedge clk);
        in_a = a; in_k = k; in_mode = m; in_tag = t; in_valid = 1'b1; out_ready = 1'b0;
        #1 chk("accept_ready", in_ready, 1);
        @(posedge clk);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_a = ~a;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) chk("timeout_run8", out_valid, 1);
        q = out_q; tg = out_tag;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle_after_done", {busy, out_valid, in_ready}, 3'b001);
    endtask

    logic [7:0] q;
    logic [1:0] tg;
    int         lat;
    logic [9:0] exp_fifo[$];
    logic [9:0] e;
    int         seen;

    task automatic rnd_pop();
        if (out_valid && out_ready) begin
            if (exp_fifo.size() == 0) begin
                chk("rnd_unexpected_out", 1, 0);
            end else begin
                e = exp_fifo.pop_front();
                chk("rnd_q", out_q, e[7:0]);
                chk("rnd_tag", out_tag, e[9:8]);
            end
        end
    endtask

    initial begin
        vecs[0] = '{8'h80, 3'd1, 1'b1, 2'd0, 8'h9A, 2};
        vecs[1] = '{8'h02, 3'd1, 1'b1, 2'd1, 8'h04, 2};
        vecs[2] = '{8'h53, 3'd0, 1'b1, 2'd2, 8'h53, 1};
        vecs[3] = '{8'h01, 3'd7, 1'b0, 2'd3, 8'h80, 8};
        vecs[4] = '{8'h53, 3'd1, 1'b1, 2'd0, 8'hB5, 2};
        vecs[5] = '{8'hA5, 3'd3, 1'b0, 2'd2, 8'h2D, 4};
        vecs[6] = '{8'h80, 3'd2, 1'b1, 2'd1, 8'hC5, 3};

        rst_n = 1'b0;
        in_valid = 0; in_a = 0; in_k = 0; in_mode = 0; in_tag = 0; out_ready = 0;
        d2_in_valid = 0; d2_in_a = 0; d2_in_k = 0; d2_in_mode = 0; d2_in_tag = 0; d2_out_ready = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", {in_ready, out_valid, busy, out_q, out_tag}, {1'b1, 1'b0, 1'b0, 8'h00, 2'b00});
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_release_idle", {busy, in_ready}, 2'b01);

        // Table-driven directed vectors.
        for (int i = 0; i < 7; i++) begin
            run8(vecs[i].a, vecs[i].k, vecs[i].mode, vecs[i].tag, q, tg, lat);
            chk($sformatf("vec%0d_q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_tag", i), tg, vecs[i].tag);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // W=2: normal basis swap, then polynomial basis x^2 = x+1.
        @(negedge clk);
        d2_in_a = 2'b01; d2_in_k = 1'b1; d2_in_mode = 1'b0; d2_in_tag = 2'd2; d2_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d2_in_valid = 1'b0;
        chk("w2_not_yet", d2_out_valid, 0);
        @(negedge clk);
        chk("w2_valid_lat2", d2_out_valid, 1);
        chk("w2_swap_q", d2_out_q, 2'b10);
        chk("w2_tag", d2_out_tag, 2'd2);
        d2_in_a = 2'b10; d2_in_mode = 1'b1; d2_in_tag = 2'd1; d2_in_valid = 1'b1; d2_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d2_in_valid = 1'b0; d2_out_ready = 1'b0;
        @(negedge clk);
        chk("w2_poly_q", {d2_out_valid, d2_out_q, d2_out_tag}, {1'b1, 2'b11, 2'd1});
        d2_out_ready = 1'b1;
        @(negedge clk);
        d2_out_ready = 1'b0;
        chk("w2_idle", d2_busy, 0);

        // Backpressure in DONE, then same-edge handoff.
        @(negedge clk);
        in_a = 8'h01; in_k = 3'd2; in_mode = 1'b0; in_tag = 2'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_a = 8'hFF; in_k = 3'd0; in_tag = 2'd0;
        seen = 0;
        for (int c = 0; c < 20 && !out_valid; c++) @(negedge clk);
        chk("bp_reached_done", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_q !== 8'h04 || out_tag !== 2'd3 || in_ready !== 1'b0) seen++;
        end
        chk("bp_stable_5", seen, 0);
        in_a = 8'h01; in_k = 3'd0; in_mode = 1'b0; in_tag = 2'd1; out_ready = 1'b1;
        #1 chk("bp_handoff_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_next_result", {out_valid, out_q, out_tag}, {1'b1, 8'h01, 2'd1});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset pulse during RUN.
        in_a = 8'h01; in_k = 3'd5; in_mode = 1'b0; in_tag = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_busy_run", busy, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst_async_outputs", {in_ready, out_valid, busy, out_q, out_tag}, {1'b1, 1'b0, 1'b0, 8'h00, 2'b00});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_no_out_beat", seen, 0);
        chk("rst_idle_after", {in_ready, busy, out_q, out_tag}, {1'b1, 1'b0, 8'h00, 2'b00});

        // Randomised stream with random backpressure.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_a = 8'($urandom);
            in_k = 3'($urandom_range(0, 7));
            in_mode = 1'($urandom_range(0, 1));
            in_tag = 2'($urandom_range(0, 3));
            #1;
            rnd_pop();
            if (in_valid && in_ready) exp_fifo.push_back({in_tag, ref_frob(in_a, int'(in_k), in_mode)});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 40 && exp_fifo.size() != 0; c++) begin
            #1 rnd_pop();
            @(negedge clk);
        end
        chk("rnd_drained", exp_fifo.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
